// File: rtl/clock_monitor.sv
// Measures high time, low time and period of an asynchronous square wave in system-clock
// cycles, and flags the input as stuck when no edge arrives within TIMEOUT cycles.
module clock_monitor #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitRise,
    StMeasHigh,
    StMeasLow,
    StStuck
  } state_e;

  localparam logic [CNT_W-1:0] TcntLast = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  state_e           state;
  logic             sync1, s, d;
  logic [CNT_W-1:0] hcnt, lcnt, tcnt;

  logic rise, fall, edge_seen, timeout_hit;

  always_comb begin
    rise        = s & ~d;
    fall        = ~s & d;
    edge_seen   = rise | fall;
    timeout_hit = (tcnt == TcntLast) && !edge_seen;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= StIdle;
      sync1       <= 1'b0;
      s           <= 1'b0;
      d           <= 1'b0;
      hcnt        <= '0;
      lcnt        <= '0;
      tcnt        <= '0;
      high_cnt    <= '0;
      low_cnt     <= '0;
      period      <= '0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      sync1      <= sig_in;
      s          <= sync1;
      d          <= s;
      meas_valid <= 1'b0;

      if (state != StIdle && !enable) begin
        // Disable wins over any edge or timeout; measurement outputs are kept.
        state       <= StIdle;
        stuck       <= 1'b0;
        stuck_level <= 1'b0;
        hcnt        <= '0;
        lcnt        <= '0;
        tcnt        <= '0;
      end else begin
        if (state == StIdle || edge_seen) begin
          tcnt <= '0;
        end else if (state != StStuck) begin
          tcnt <= tcnt + 1'b1;
        end

        unique case (state)
          StIdle: begin
            if (enable) state <= StWaitRise;
          end
          StWaitRise: begin
            if (rise) begin
              state <= StMeasHigh;
              hcnt  <= CNT_W'(1);
            end else if (timeout_hit) begin
              state       <= StStuck;
              stuck       <= 1'b1;
              stuck_level <= s;
              hcnt        <= '0;
              lcnt        <= '0;
            end
          end
          StMeasHigh: begin
            if (fall) begin
              state <= StMeasLow;
              lcnt  <= CNT_W'(1);
            end else if (timeout_hit) begin
              state       <= StStuck;
              stuck       <= 1'b1;
              stuck_level <= s;
              hcnt        <= '0;
              lcnt        <= '0;
            end else if (hcnt != CntMax) begin
              hcnt <= hcnt + 1'b1;
            end
          end
          StMeasLow: begin
            if (rise) begin
              high_cnt   <= hcnt;
              low_cnt    <= lcnt;
              period     <= {1'b0, hcnt} + {1'b0, lcnt};
              meas_valid <= 1'b1;
              state      <= StMeasHigh;
              hcnt       <= CNT_W'(1);
            end else if (timeout_hit) begin
              state       <= StStuck;
              stuck       <= 1'b1;
              stuck_level <= s;
              hcnt        <= '0;
              lcnt        <= '0;
            end else if (lcnt != CntMax) begin
              lcnt <= lcnt + 1'b1;
            end
          end
          StStuck: begin
            if (rise) begin
              stuck       <= 1'b0;
              stuck_level <= 1'b0;
              state       <= StMeasHigh;
              hcnt        <= CNT_W'(1);
            end else if (fall) begin
              stuck       <= 1'b0;
              stuck_level <= 1'b0;
              state       <= StWaitRise;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: periodic waveforms, timeout, disable, async reset, glitch.
module tb_clock_monitor;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 20;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] high_cnt, low_cnt;
  logic [CNT_W:0]   period;
  logic             meas_valid, stuck, stuck_level;

  clock_monitor #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .sig_in     (sig_in),
    .high_cnt   (high_cnt),
    .low_cnt    (low_cnt),
    .period     (period),
    .meas_valid (meas_valid),
    .stuck      (stuck),
    .stuck_level(stuck_level)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Report monitor: pulse count, back-to-back pulses, last reported values.
  int               vcount = 0;
  int               dbl = 0;
  logic             prev_mv = 1'b0;
  logic [CNT_W-1:0] cap_h = '0, cap_l = '0;
  logic [CNT_W:0]   cap_p = '0;

  always @(negedge clock) begin
    prev_mv <= meas_valid;
    if (meas_valid === 1'b1) begin
      vcount <= vcount + 1;
      cap_h  <= high_cnt;
      cap_l  <= low_cnt;
      cap_p  <= period;
      if (prev_mv === 1'b1) dbl <= dbl + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at posedge+1; sig_in is high for h samples, then low for l samples.
  task automatic wave(input int h, input int l);
    sig_in = 1'b1;
    repeat (h) begin @(posedge clock); #1; end
    sig_in = 1'b0;
    repeat (l) begin @(posedge clock); #1; end
  endtask

  task automatic check_report(input string tag, input int base, input int h, input int l);
    check_eq({tag, "_cnt"}, vcount, base + 1);
    check_eq({tag, "_high"}, cap_h, h);
    check_eq({tag, "_low"}, cap_l, l);
    check_eq({tag, "_period"}, cap_p, h + l);
  endtask

  int base;

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_high", high_cnt, 0);
    check_eq("rst_low", low_cnt, 0);
    check_eq("rst_period", period, 0);
    check_eq("rst_valid", meas_valid, 0);
    check_eq("rst_stuck", stuck, 0);
    check_eq("rst_level", stuck_level, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    enable = 1'b1;
    repeat (2) begin @(posedge clock); #1; end

    // 5/5 square wave: first rise only starts the measurement
    wave(5, 5);
    check_eq("sq_first_no_valid", vcount, 0);
    for (int i = 0; i < 4; i++) begin
      base = vcount;
      wave(5, 5);
      check_report("sq55", base, 5, 5);
    end

    // 3/7 waveform, one settling period then five checked periods
    wave(3, 7);
    for (int i = 0; i < 5; i++) begin
      base = vcount;
      wave(3, 7);
      check_report("hl37", base, 3, 7);
    end
    check_eq("no_double_valid", dbl, 0);

    // Timeout: rise processed 3 edges after drive, stuck 20 edges later
    sig_in = 1'b1;
    repeat (22) @(posedge clock);
    @(negedge clock);
    check_eq("stuck_early", stuck, 0);
    @(posedge clock);
    @(negedge clock);
    check_eq("stuck_set", stuck, 1);
    check_eq("stuck_level_hi", stuck_level, 1);
    @(posedge clock); #1;
    sig_in = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("stuck_hold", stuck, 1);
    @(posedge clock);
    @(negedge clock);
    check_eq("stuck_clear", stuck, 0);
    check_eq("stuck_level_clr", stuck_level, 0);
    base = vcount;
    @(posedge clock); #1;
    wave(5, 5);
    check_eq("after_stuck_no_valid", vcount, base);
    wave(5, 5);
    check_report("after_stuck", base, 5, 5);

    // Disable for 4 cycles while measuring high phase
    sig_in = 1'b1;
    repeat (5) begin @(posedge clock); end
    #1;
    base = vcount;
    enable = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    enable = 1'b1;
    @(negedge clock);
    check_eq("dis_valid_cnt", vcount, base);
    check_eq("dis_stuck", stuck, 0);
    check_eq("dis_high_held", high_cnt, 5);
    check_eq("dis_low_held", low_cnt, 5);
    check_eq("dis_period_held", period, 10);
    @(posedge clock); #1;
    repeat (2) begin @(posedge clock); #1; end
    sig_in = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    wave(4, 8);
    check_eq("reen_first_no_valid", vcount, base);
    wave(4, 8);
    check_report("reen", base, 4, 8);

    // Async reset mid-cycle while in the low phase
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_high", high_cnt, 0);
    check_eq("arst_low", low_cnt, 0);
    check_eq("arst_period", period, 0);
    check_eq("arst_valid", meas_valid, 0);
    check_eq("arst_stuck", stuck, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    base = vcount;
    wave(5, 5);
    check_eq("post_rst_no_valid", vcount, base);
    wave(5, 5);
    check_report("post_rst", base, 5, 5);

    // One-cycle glitch high, nine low
    wave(1, 9);
    base = vcount;
    wave(1, 9);
    check_report("glitch", base, 1, 9);
    check_eq("final_no_double", dbl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clock_monitor.md
Name: clock_monitor

Overview:
- Receiver-side companion to the clock generator. Samples a free-running square wave `sig_in` on the system clock and measures its high time, low time and period in system-clock cycles.
- Raises a `stuck` flag when the monitored signal stops toggling.
- Used in benches and on-chip to check generated clocks and strobes against their expected timing.

Parameters:
- CNT_W, 16: width of the high/low counters. Counters saturate at 2^CNT_W-1.
- TIMEOUT, 1000: number of cycles without any edge before `stuck` asserts. Must be in the range 2 to 2^CNT_W-1.

Ports:
- clock  input  1  system clock. All logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  synchronous measurement enable.
- sig_in  input  1  monitored signal, asynchronous to `clock`.
- high_cnt  output  CNT_W  last complete high-phase length, in cycles.
- low_cnt  output  CNT_W  last complete low-phase length, in cycles.
- period  output  CNT_W+1  high_cnt + low_cnt of the last complete period.
- meas_valid  output  1  one-cycle pulse when all three measurement outputs update.
- stuck  output  1  no edge seen for TIMEOUT cycles.
- stuck_level  output  1  synchronized level of `sig_in` while `stuck` is 1. Otherwise 0.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State IDLE.
  - Synchronizer flops, delayed-sample flop, internal counters and all outputs reset to 0.
- Input conditioning and edge detection:
  - `sig_in` passes through a 2-flop synchronizer giving `s`.
  - `d` is `s` delayed by one cycle.
  - rise = s & ~d; fall = ~s & d.
  - An edge on `sig_in` is detected 3 clock edges after it is sampled.
- States: IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW, STUCK.
- IDLE: stays while enable=0. When enable=1, go to WAIT_RISE and clear the timeout counter.
- WAIT_RISE:
  - Ignores fall.
  - On rise: go to MEAS_HIGH, hcnt<=1.
- MEAS_HIGH:
  - Each cycle without fall: hcnt<=hcnt+1, saturating.
  - On fall: go to MEAS_LOW, lcnt<=1.
- MEAS_LOW:
  - Each cycle without rise: lcnt<=lcnt+1, saturating.
  - On rise, in the same cycle: high_cnt<=hcnt, low_cnt<=lcnt, period<=hcnt+lcnt (zero-extended, no overflow possible), meas_valid<=1, go to MEAS_HIGH with hcnt<=1.
- Resulting values: a stable input with H cycles high and L cycles low reports high_cnt=H, low_cnt=L, period=H+L. The first valid report follows the second detected rise after enable.
- meas_valid is a registered single-cycle pulse. Measurement outputs hold their values until the next update.
- Timeout:
  - `tcnt` counts cycles since the last detected edge in every state except IDLE. Any edge resets it to 0.
  - When tcnt reaches TIMEOUT-1 with no edge in that cycle: go to STUCK, stuck<=1, stuck_level<=s, and clear hcnt and lcnt.
  - Measurement outputs are not cleared on timeout.
- STUCK:
  - On rise: stuck<=0, stuck_level<=0, go to MEAS_HIGH, hcnt<=1.
  - On fall: stuck<=0, stuck_level<=0, go to WAIT_RISE.
- Priorities:
  - enable=0 beats everything in any non-IDLE state. Next cycle: IDLE, stuck=0, stuck_level=0, internal counters cleared, measurement outputs held, no meas_valid.
  - An edge beats a timeout in the same cycle: the edge is processed and tcnt is cleared.
- Glitches: a 1-cycle pulse (after synchronization) is measured as high_cnt=1. No filtering.
- Saturation: hcnt/lcnt stick at 2^CNT_W-1 and report that value. This can occur only if TIMEOUT > 2^CNT_W-1, which the parameter range excludes.
- Reset mid-operation: immediate return to reset values. No meas_valid is generated.

Test Plan:
- Reset, enable=1, sig_in toggling every 5 cycles (10-cycle period) -> meas_valid pulses every 10 cycles; high_cnt=5, low_cnt=5, period=10. First pulse after the second detected rise.
- sig_in high 3 cycles, low 7 cycles, repeating -> high_cnt=3, low_cnt=7, period=10, stable over 5 periods. meas_valid is never high for 2 consecutive cycles.
- TIMEOUT=20, sig_in held at 1 after a rise -> stuck=1 and stuck_level=1 exactly 20 cycles after the last detected edge. Then drop sig_in -> stuck=0 one cycle after the fall is detected; state WAIT_RISE; no meas_valid until two further rises.
- Mid-measurement enable=0 for 4 cycles, then re-enabled -> outputs hold prior values, no meas_valid, stuck=0; next report is the fresh correct period.
- reset_n pulsed low asynchronously (not on a clock edge) while in MEAS_LOW -> all outputs read 0 immediately. After release, same behaviour as from power-up.
- 1-cycle-wide high pulse (synchronous to clock), then 9 cycles low -> high_cnt=1, low_cnt=9, period=10.
